stdp_update: RTL and testbench

- Downstream learning stage for the combinational spike-accumulating neuron.
- Observes one gamma window of input spikes and the neuron's output spike, records first-spike times, then applies a temporal STDP rule to the synapse weights.
- Weight changes are saturating, one synapse per cycle.
- Updated weights go back to the weight store that feeds the neuron's weights bus.

---
 rtl/stdp_pkg.sv | 46 ++++
 rtl/stdp_rule.sv | 33 +++
 rtl/stdp_update.sv | 134 +++++++++++++
 tb/tb_stdp_update.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/stdp_pkg.sv
// Shared types, fixed learning constants and saturating weight arithmetic
// for the STDP weight-update stage.
package stdp_pkg;

    localparam int NUM_SPIKES_DEF = 8;
    localparam int WBITS          = 3;
    localparam int GAMMA          = 8;
    localparam int TBITS          = $clog2(GAMMA);
    localparam int WMAX           = 2**WBITS - 1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        OBSERVE = 2'd1,
        UPDATE  = 2'd2,
        DONE    = 2'd3
    } state_t;

    typedef logic [WBITS-1:0] weight_t;
    typedef logic [TBITS-1:0] time_t;

    localparam weight_t         INC      = weight_t'(1);
    localparam weight_t         DEC      = weight_t'(1);
    localparam logic [WBITS:0]  WMAX_EXT = (WBITS+1)'(WMAX);

    // One guard bit catches overflow before it can wrap.
    function automatic weight_t sat_add(input weight_t w, input weight_t step);
        logic [WBITS:0] w_sum;
        w_sum = {1'b0, w} + {1'b0, step};
        if (w_sum > WMAX_EXT) begin
            sat_add = weight_t'(WMAX);
        end else begin
            sat_add = w_sum[WBITS-1:0];
        end
    endfunction

    function automatic weight_t sat_sub(input weight_t w, input weight_t step);
        logic [WBITS:0] w_diff;
        w_diff = {1'b0, w} - {1'b0, step};
        if (w_diff[WBITS]) begin
            sat_sub = '0;
        end else begin
            sat_sub = w_diff[WBITS-1:0];
        end
    endfunction

endpackage

// File: rtl/stdp_rule.sv
// Combinational temporal STDP rule for a single synapse: decides potentiate,
// depress or hold from first-spike times and applies saturating arithmetic.
module stdp_rule
    import stdp_pkg::*;
(
    input  weight_t i_w,
    input  logic    i_in_seen,
    input  logic    i_out_seen,
    input  time_t   i_t_in,
    input  time_t   i_t_out,
    input  logic    i_learn_en,
    output weight_t o_w_new
);

    // Equal spike times count as causal; an output spike with no input depresses.
    always_comb begin
        o_w_new = i_w;
        if (!i_learn_en) begin
            o_w_new = i_w;
        end else if (i_in_seen && i_out_seen) begin
            if (i_t_in <= i_t_out) begin
                o_w_new = sat_add(i_w, INC);
            end else begin
                o_w_new = sat_sub(i_w, DEC);
            end
        end else if (!i_in_seen && i_out_seen) begin
            o_w_new = sat_sub(i_w, DEC);
        end else begin
            o_w_new = i_w;
        end
    end

endmodule

// File: rtl/stdp_update.sv
// STDP learning stage: observes one GAMMA-cycle window of spikes, records
// first-spike times, then updates one synapse weight per cycle.
module stdp_update
    import stdp_pkg::*;
#(
    parameter int NUM_SPIKES = NUM_SPIKES_DEF
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_start,
    input  logic                     i_learn_en,
    input  logic [NUM_SPIKES-1:0]    i_spikes_in,
    input  logic                     i_spike_out,
    input  weight_t [NUM_SPIKES-1:0] i_weights_in,
    output weight_t [NUM_SPIKES-1:0] o_weights_out,
    output logic                     o_weights_valid,
    output logic                     o_busy
);

    localparam int KW = (NUM_SPIKES > 1) ? $clog2(NUM_SPIKES) : 1;

    state_t                   r_state;
    time_t                    r_t;
    logic [KW-1:0]            r_k;
    logic                     r_learn;
    logic [NUM_SPIKES-1:0]    r_in_seen;
    time_t [NUM_SPIKES-1:0]   r_t_in;
    logic                     r_out_seen;
    time_t                    r_t_out;
    weight_t [NUM_SPIKES-1:0] r_w;
    weight_t [NUM_SPIKES-1:0] r_weights_out;
    logic                     r_valid;
    logic                     r_busy;

    weight_t                  w_rule_new;
    weight_t [NUM_SPIKES-1:0] w_next;

    stdp_rule u_rule (
        .i_w        (r_w[r_k]),
        .i_in_seen  (r_in_seen[r_k]),
        .i_out_seen (r_out_seen),
        .i_t_in     (r_t_in[r_k]),
        .i_t_out    (r_t_out),
        .i_learn_en (r_learn),
        .o_w_new    (w_rule_new)
    );

    // Working array with the synapse selected by k replaced by its new weight.
    always_comb begin
        w_next      = r_w;
        w_next[r_k] = w_rule_new;
    end

    // Window FSM: capture, observe first spikes, sweep synapses, publish.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state       <= IDLE;
            r_t           <= '0;
            r_k           <= '0;
            r_learn       <= 1'b0;
            r_in_seen     <= '0;
            r_t_in        <= '0;
            r_out_seen    <= 1'b0;
            r_t_out       <= '0;
            r_w           <= '0;
            r_weights_out <= '0;
            r_valid       <= 1'b0;
            r_busy        <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_valid <= 1'b0;
                    if (i_start) begin
                        r_w        <= i_weights_in;
                        r_learn    <= i_learn_en;
                        r_t        <= '0;
                        r_k        <= '0;
                        r_in_seen  <= '0;
                        r_t_in     <= '0;
                        r_out_seen <= 1'b0;
                        r_t_out    <= '0;
                        r_busy     <= 1'b1;
                        r_state    <= OBSERVE;
                    end else begin
                        r_state <= IDLE;
                    end
                end
                OBSERVE: begin
                    for (int i = 0; i < NUM_SPIKES; i++) begin
                        if (i_spikes_in[i] && !r_in_seen[i]) begin
                            r_in_seen[i] <= 1'b1;
                            r_t_in[i]    <= r_t;
                        end
                    end
                    if (i_spike_out && !r_out_seen) begin
                        r_out_seen <= 1'b1;
                        r_t_out    <= r_t;
                    end
                    if (r_t == time_t'(GAMMA - 1)) begin
                        r_k     <= '0;
                        r_state <= UPDATE;
                    end else begin
                        r_t <= r_t + time_t'(1);
                    end
                end
                UPDATE: begin
                    r_w <= w_next;
                    if (r_k == KW'(NUM_SPIKES - 1)) begin
                        r_weights_out <= w_next;
                        r_valid       <= 1'b1;
                        r_state       <= DONE;
                    end else begin
                        r_k <= r_k + KW'(1);
                    end
                end
                DONE: begin
                    r_valid <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
                default: begin
                    r_valid <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign o_weights_out   = r_weights_out;
    assign o_weights_valid = r_valid;
    assign o_busy          = r_busy;

endmodule

// File: tb/tb_stdp_update.sv
// Self-checking bench for stdp_update (4 synapses): directed vector table,
// reset corner cases and randomized windows against a first-spike-time model.
module tb_stdp_update;
    import stdp_pkg::*;

    localparam int N = 4;
    localparam int G = GAMMA;
    localparam int LAT = 1 + G + N;

    typedef logic [G-1:0][N-1:0] sin_t;
    typedef weight_t [N-1:0]     wv_t;

    typedef struct {
        wv_t          w;
        bit           learn;
        sin_t         sin;
        logic [G-1:0] sout;
        int           second;
        wv_t          exp_w;
    } vec_t;

    logic   clk = 1'b0;
    logic   rst;
    logic   start;
    logic   learn_en;
    logic [N-1:0] spikes_in;
    logic   spike_out;
    wv_t    weights_in;
    wv_t    weights_out;
    logic   weights_valid;
    logic   busy;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    stdp_update #(.NUM_SPIKES(N)) dut (
        .i_clk           (clk),
        .i_rst           (rst),
        .i_start         (start),
        .i_learn_en      (learn_en),
        .i_spikes_in     (spikes_in),
        .i_spike_out     (spike_out),
        .i_weights_in    (weights_in),
        .o_weights_out   (weights_out),
        .o_weights_valid (weights_valid),
        .o_busy          (busy)
    );

    task automatic check(input string name, input int act, input int exp_v);
        total++;
        if (act != exp_v) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp_v);
        end
    endtask

    function automatic wv_t mkw(input int a, input int b, input int c, input int d);
        wv_t r;
        r[0] = weight_t'(a);
        r[1] = weight_t'(b);
        r[2] = weight_t'(c);
        r[3] = weight_t'(d);
        return r;
    endfunction

    // Reference: find first-spike times, then apply the rule with plain integers.
    function automatic wv_t model(input wv_t w, input bit learn, input sin_t sin,
                                  input logic [G-1:0] sout);
        int  tin [N];
        int  tout;
        int  v;
        wv_t r;
        tout = -1;
        for (int t = G - 1; t >= 0; t--) if (sout[t]) tout = t;
        for (int i = 0; i < N; i++) begin
            tin[i] = -1;
            for (int t = G - 1; t >= 0; t--) if (sin[t][i]) tin[i] = t;
        end
        for (int i = 0; i < N; i++) begin
            v = int'(w[i]);
            if (learn && tout >= 0) begin
                if (tin[i] >= 0 && tin[i] <= tout) v = v + 1;
                else v = v - 1;
            end
            if (v > 7) v = 7;
            if (v < 0) v = 0;
            r[i] = weight_t'(v);
        end
        return r;
    endfunction

    task automatic run_window(input wv_t w, input bit learn, input sin_t sin,
                              input logic [G-1:0] sout, input int second,
                              output wv_t wout, output int lat, output int nvalid);
        int t;
        lat        = -1;
        nvalid     = 0;
        wout       = '0;
        weights_in = w;
        learn_en   = learn;
        start      = 1'b1;
        spikes_in  = '0;
        spike_out  = 1'b0;
        for (int e = 1; e <= 24; e++) begin
            if (e >= 2) begin
                t     = e - 2;
                start = (t == second);
                if (t < G) begin
                    spikes_in = sin[t];
                    spike_out = sout[t];
                end else begin
                    spikes_in = '0;
                    spike_out = 1'b0;
                end
            end
            @(posedge clk);
            #1;
            if (e == 1) check("busy_after_start", int'(busy), 1);
            if (weights_valid) begin
                nvalid++;
                if (lat < 0) begin
                    lat  = e;
                    wout = weights_out;
                end
            end
        end
        start = 1'b0;
    endtask

    task automatic run_and_check(input string name, input wv_t w, input bit learn,
                                 input sin_t sin, input logic [G-1:0] sout,
                                 input int second, input wv_t exp_w);
        wv_t wout;
        int  lat;
        int  nvalid;
        run_window(w, learn, sin, sout, second, wout, lat, nvalid);
        check({name, "_latency"}, lat, LAT);
        check({name, "_valid_count"}, nvalid, 1);
        check({name, "_weights"}, int'(wout), int'(exp_w));
        check({name, "_weights_held"}, int'(weights_out), int'(exp_w));
        check({name, "_idle"}, int'(busy), 0);
    endtask

    vec_t vecs[8];

    initial begin
        wv_t          rw;
        bit           rl;
        sin_t         rs;
        logic [G-1:0] ro;
        int           nv;

        rst        = 1'b1;
        start      = 1'b0;
        learn_en   = 1'b0;
        spikes_in  = '0;
        spike_out  = 1'b0;
        weights_in = '0;
        #12;
        check("reset_weights_out", int'(weights_out), 0);
        check("reset_valid", int'(weights_valid), 0);
        check("reset_busy", int'(busy), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        for (int i = 0; i < 8; i++) begin
            vecs[i].sin    = '0;
            vecs[i].sout   = '0;
            vecs[i].second = -1;
            vecs[i].learn  = 1'b1;
        end
        // causal: synapse 0 potentiated, silent synapses depressed by the output spike
        vecs[0].w = mkw(3, 3, 3, 3); vecs[0].sin[2] = 4'b0001; vecs[0].sout[5] = 1'b1;
        vecs[0].exp_w = mkw(4, 2, 2, 2);
        vecs[1].w = mkw(3, 3, 3, 3); vecs[1].sin[6] = 4'b0010; vecs[1].sout[3] = 1'b1;
        vecs[1].exp_w = mkw(2, 2, 2, 2);
        // first-spike-only with learning disabled, then enabled
        vecs[2].w = mkw(3, 5, 0, 7); vecs[2].learn = 1'b0;
        for (int t = 0; t < G; t++) vecs[2].sin[t] = 4'b0001;
        vecs[2].sout[0] = 1'b1; vecs[2].sout[6] = 1'b1;
        vecs[2].exp_w = mkw(3, 5, 0, 7);
        vecs[3] = vecs[2]; vecs[3].learn = 1'b1;
        vecs[3].exp_w = mkw(4, 4, 0, 6);
        vecs[4].w = mkw(1, 2, 3, 4);
        vecs[4].exp_w = mkw(1, 2, 3, 4);
        vecs[5].w = mkw(1, 2, 3, 4); vecs[5].sin[0] = 4'b0010; vecs[5].sin[3] = 4'b1000;
        vecs[5].exp_w = mkw(1, 2, 3, 4);
        vecs[6] = vecs[0]; vecs[6].second = 4;
        // saturation at both ends and equal times
        vecs[7].w = mkw(7, 0, 5, 5); vecs[7].sout[4] = 1'b1;
        vecs[7].sin[4] = 4'b0001; vecs[7].sin[1] = 4'b0100; vecs[7].sin[7] = 4'b1000;
        vecs[7].exp_w = mkw(7, 0, 6, 4);

        for (int i = 0; i < 8; i++) begin
            run_and_check($sformatf("vec%0d", i), vecs[i].w, vecs[i].learn, vecs[i].sin,
                          vecs[i].sout, vecs[i].second, vecs[i].exp_w);
        end

        // asynchronous reset between clock edges while in UPDATE
        weights_in = mkw(1, 1, 1, 1);
        learn_en   = 1'b1;
        start      = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check("midreset_busy", int'(busy), 0);
        check("midreset_weights_out", int'(weights_out), 0);
        check("midreset_valid", int'(weights_valid), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        nv  = 0;
        repeat (20) begin
            @(posedge clk);
            #1;
            if (weights_valid) nv++;
        end
        check("midreset_no_valid", nv, 0);
        run_and_check("after_reset", vecs[7].w, vecs[7].learn, vecs[7].sin,
                      vecs[7].sout, -1, vecs[7].exp_w);

        for (int n = 0; n < 25; n++) begin
            for (int i = 0; i < N; i++) rw[i] = weight_t'($urandom_range(0, 7));
            rl = ($urandom_range(0, 3) != 0);
            for (int t = 0; t < G; t++) begin
                rs[t] = N'($urandom_range(0, 15) & $urandom_range(0, 15) & $urandom_range(0, 15));
                ro[t] = ($urandom_range(0, 5) == 0);
            end
            run_and_check($sformatf("rand%0d", n), rw, rl, rs, ro, -1, model(rw, rl, rs, ro));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
